dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the 1 KB data memory (synchronous-read BRAM: one cycle read latency, byte-enabled synchronous write). Port 0 serves the CPU load/store unit; port 1 serves the AXI4-Lite slave bridge (debug/DMA). One request is granted per cycle, the granted request is driven onto the memory, and a response is returned one cycle later to the issuing port.

## Interface
- ADDR_W, 12, byte address width
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive cycles a waiting port is denied before it is force-granted (fixed-priority mode only; 1..255)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle (grant)
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_be / p1_req_be  in  4  byte enables (writes only)
- p0_req_addr / p1_req_addr  in  ADDR_W  byte address
- p0_req_wdata / p1_req_wdata  in  DATA_W  write data
- p0_rsp_valid / p1_rsp_valid  out  1  response pulse, one cycle
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads, else 0
- p0_rsp_err / p1_rsp_err  out  1  misaligned access, valid with rsp_valid
- mem_write  out  1  memory write strobe
- mem_byte_en  out  4  memory byte enables
- mem_write_addr  out  ADDR_W  write address
- mem_read_addr  out  ADDR_W  read address
- mem_write_data  out  DATA_W  write data
- mem_read_data  in  DATA_W  memory read data (valid the cycle after read address sampled)

## Operation
- Grant: at most one of p0_req_ready/p1_req_ready high per cycle; ready is combinational from valid and arbitration state; a request transfers when valid && ready.
- No response backpressure; requesters must accept rsp in the pulse cycle. Throughput one request per cycle, any mix of ports.
- Granted write, addr[1:0]==0: mem_write = (be != 0), mem_byte_en = be, mem_write_addr = addr, mem_write_data = wdata, same cycle.
- Granted read, addr[1:0]==0: mem_read_addr = addr, mem_write = 0, mem_byte_en = 0.
- Misaligned (addr[1:0]!=0): accepted, no memory access (mem_write = 0), response with rsp_err = 1, rdata = 0.
- mem_read_addr holds its last value when no read granted; mem_write_addr/data/byte_en driven 0 when no write granted.
- Response pipeline register: {pending, port, is_read, err}; next cycle pulses rsp_valid on the recorded port, rdata = mem_read_data if is_read && !err.
- Fixed priority: port 0 wins; starve counter counts cycles p1_req_valid is high and not granted; at STARVE_LIMIT port 1 is granted once regardless of port 0, counter clears; counter clears on any port 1 grant or p1_req_valid low.

## Timing
- Request accepted cycle N -> rsp_valid cycle N+1, for reads, writes, errors.
- Write visible to a read granted in cycle N+1 or later (memory write completes at edge ending N).
- Reset asserted: all outputs 0 combinationally-independent state cleared immediately (pending response dropped, starve counter 0, round-robin pointer favours port 0); mem_read_addr resets to 0. Ready outputs low while rst is low.
- Reset mid-operation: response in flight is lost; requester must reissue.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; after a grant to port k, port !k has priority next contended cycle; starve counter not instantiated (STARVE_LIMIT ignored).
- Undefined: fixed priority port 0 with starvation guard as above.

## Structure
- Shared package: port index constants (PORT_CPU = 0, PORT_AXI = 1), response-record typedef {pending, port, is_read, err}, default ADDR_W/DATA_W.
- One sub-module: dmem_arb_grant (combinational grant from valids, priority pointer/starve flag); top holds pointer, starve counter, response pipeline, memory muxing.

## Test plan
- Port 0 write 0xDEADBEEF to 0x010 be=4'hF, then read 0x010 -> p0_rsp_valid at N+1 each, read rdata 0xDEADBEEF.
- Both ports read every cycle for 20 cycles, fixed priority, STARVE_LIMIT=8 -> port 1 granted on cycle 9, then again after 8 more; all other grants port 0.
- Same stimulus with DMEM_ARB_RR_EN -> grants alternate 0,1,0,1; each rsp on correct port only.
- Port 1 write 0x12345678 be=4'b0011 over 0xFFFFFFFF at 0x020, read back -> 0xFFFF5678.
- Port 0 read at 0x013 -> rsp_err=1, rdata=0, mem_write=0, mem_read_addr unchanged.
- Assert rst low in cycle after a grant -> no rsp_valid, all outputs 0; after release, first request served normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, the
// response pipeline record and default bus widths.
package dmem_arbiter_pkg;

    localparam int PORT_CPU   = 0;
    localparam int PORT_AXI   = 1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // One in-flight response: which port issued it, whether read data must
    // be returned, and whether the access was rejected as misaligned.
    typedef struct packed {
        logic pending;
        logic port;
        logic is_read;
        logic err;
    } rsp_rec_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant for the two requesters. Port 0 wins contention unless
// p1_prio is raised (round-robin pointer or starvation flag from the top).
// No grant is issued while en is low, so both readies drop during reset.
module dmem_arb_grant (
    input  logic en,
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic p1_prio,
    output logic p0_grant,
    output logic p1_grant
);

    // At most one grant; port 1 only beats a waiting port 0 when prioritised.
    always_comb begin
        p1_grant = en & p1_valid & (~p0_valid | p1_prio);
        p0_grant = en & p0_valid & ~p1_grant;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 1 KB synchronous-read data BRAM.
// Port 0 = CPU load/store unit, port 1 = AXI4-Lite bridge. One request is
// granted per cycle and answered exactly one cycle later on its own port.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority and port 1 is protected by a starvation counter.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [3:0]        p0_req_be,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [3:0]        p1_req_be,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_write,
    output logic [3:0]        mem_byte_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic              gnt0, gnt1, accept, p1_prio;
    logic              sel_we, aligned, wr_go, rd_go;
    logic [3:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr, rd_addr_q;
    logic [DATA_W-1:0] sel_wdata;
    rsp_rec_t          rsp_p1;

    dmem_arb_grant u_grant (
        .en       (rst),
        .p0_valid (p0_req_valid),
        .p1_valid (p1_req_valid),
        .p1_prio  (p1_prio),
        .p0_grant (gnt0),
        .p1_grant (gnt1)
    );

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // Round-robin pointer: the port that just lost the grant is favoured next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      rr_ptr <= 1'b0;
        else if (gnt0) rr_ptr <= 1'b1;
        else if (gnt1) rr_ptr <= 1'b0;
    end

    assign p1_prio = rr_ptr;
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] starve_cnt;

    // Count consecutive cycles port 1 waits; reaching LIMIT forces one grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       starve_cnt <= 8'd0;
        else if (gnt1 || !p1_req_valid) starve_cnt <= 8'd0;
        else                            starve_cnt <= starve_cnt + 8'd1;
    end

    assign p1_prio = (starve_cnt >= LIMIT);
`endif

    // Steer the granted request's fields toward the memory.
    always_comb begin
        accept    = gnt0 | gnt1;
        sel_we    = gnt1 ? p1_req_we    : p0_req_we;
        sel_be    = gnt1 ? p1_req_be    : p0_req_be;
        sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
        sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;
        aligned   = (sel_addr[1:0] == 2'b00);
        wr_go     = accept & sel_we & aligned;
        rd_go     = accept & ~sel_we & aligned;
    end

    // Memory drive: write fields are zero unless an aligned write is granted;
    // the read address falls back to its last granted value.
    always_comb begin
        mem_write      = wr_go & (sel_be != 4'h0);
        mem_byte_en    = wr_go ? sel_be    : 4'h0;
        mem_write_addr = wr_go ? sel_addr  : '0;
        mem_write_data = wr_go ? sel_wdata : '0;
        mem_read_addr  = rd_go ? sel_addr  : rd_addr_q;
    end

    // Remember the last read address so the BRAM port stays stable when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_addr_q <= '0;
        else if (rd_go) rd_addr_q <= sel_addr;
    end

    // ---- stage p1: response record for the request accepted this cycle ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_p1 <= '0;
        else      rsp_p1 <= '{pending: accept, port: gnt1, is_read: ~sel_we, err: ~aligned};
    end

    // Pulse the response on the recorded port; read data only for good reads.
    always_comb begin
        p0_rsp_valid = rsp_p1.pending & (rsp_p1.port == 1'(PORT_CPU));
        p1_rsp_valid = rsp_p1.pending & (rsp_p1.port == 1'(PORT_AXI));
        p0_rsp_err   = p0_rsp_valid & rsp_p1.err;
        p1_rsp_err   = p1_rsp_valid & rsp_p1.err;
        p0_rsp_rdata = (p0_rsp_valid && rsp_p1.is_read && !rsp_p1.err) ? mem_read_data : '0;
        p1_rsp_rdata = (p1_rsp_valid && rsp_p1.is_read && !rsp_p1.err) ? mem_read_data : '0;
    end

endmodule
